// File: rtl/mem_pkg.sv
// mem_pkg: shared definitions for the memory responder.
//   DEF_WORD_SIZE : default data/address width
//   CNT_BITS      : latency counter width (LATENCY up to 15)
//   state_t       : per-port FSM states IDLE / WAIT / DONE
//   op_t          : latched access type OP_READ / OP_WRITE
package mem_pkg;
  localparam int DEF_WORD_SIZE = 16;
  localparam int CNT_BITS      = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_t;
endpackage

// File: rtl/mem_port_fsm.sv
// mem_port_fsm: latency-counting access FSM for one memory port.
// Ports:
//   clk, reset   : clock, asynchronous active-high reset
//   rd_req       : read request (held by requester until ready)
//   wr_req       : write request (wins over rd_req when both are high)
//   address      : word address, already reduced to ADDR_BITS
//   ready        : high for the single DONE cycle
//   sample       : request accepted this cycle (IDLE with a request)
//   enter_done   : the coming edge moves the FSM into DONE
//   mem_addr     : address the top should use for the array this cycle
//   write_op     : latched op is a write
module mem_port_fsm
  import mem_pkg::*;
#(
  parameter int ADDR_BITS = 8,
  parameter int LATENCY   = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rd_req,
  input  logic                 wr_req,
  input  logic [ADDR_BITS-1:0] address,
  output logic                 ready,
  output logic                 sample,
  output logic                 enter_done,
  output logic [ADDR_BITS-1:0] mem_addr,
  output logic                 write_op
);
  state_t                state_reg, state_next;
  logic [CNT_BITS-1:0]   cnt_reg, cnt_next;
  logic [ADDR_BITS-1:0]  addr_reg, addr_next;
  op_t                   op_reg, op_next;
  logic                  req;

  assign req = rd_req | wr_req;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      addr_reg  <= '0;
      op_reg    <= OP_READ;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      addr_reg  <= addr_next;
      op_reg    <= op_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    addr_next  = addr_reg;
    op_next    = op_reg;
    sample     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (req) begin
          sample     = 1'b1;
          addr_next  = address;
          op_next    = wr_req ? OP_WRITE : OP_READ;
          cnt_next   = CNT_BITS'(LATENCY - 1);
          state_next = (LATENCY == 1) ? DONE : WAIT;
        end
      end
      WAIT: begin
        // A dropped request abandons the access: no ready, no commit.
        if (!req) begin
          state_next = IDLE;
        end else if (cnt_reg <= CNT_BITS'(1)) begin
          cnt_next   = '0;
          state_next = DONE;
        end else begin
          cnt_next = cnt_reg - CNT_BITS'(1);
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign ready      = (state_reg == DONE);
  assign enter_done = (state_reg != DONE) && (state_next == DONE);
  // With LATENCY=1 DONE is entered on the sample edge itself, so the
  // array must see the live address rather than the not-yet-latched one.
  assign mem_addr   = (state_reg == IDLE) ? address : addr_reg;
  assign write_op   = (op_reg == OP_WRITE);
endmodule

// File: rtl/mem_responder.sv
// mem_responder: multi-cycle memory shared by an instruction port (read
// only) and a data port (read/write), each with its own latency FSM.
// Ports:
//   clk, reset              : clock, asynchronous active-high reset
//   i_readM/i_writeM        : instruction request (i_writeM ignored)
//   i_address, i_data       : instruction address / tri-state read bus
//   i_ready                 : one-cycle completion pulse
//   d_readM/d_writeM        : data request (both high = write + err)
//   d_address, d_data       : data address / bidirectional bus
//   d_ready                 : one-cycle completion pulse
//   err                     : sticky protocol error
//   rd_count, wr_count      : saturating access counters, present only
//                             when MEM_RESP_STATS_EN is defined
module mem_responder
  import mem_pkg::*;
#(
  parameter int    WORD_SIZE = DEF_WORD_SIZE,
  parameter int    ADDR_BITS = 8,
  parameter int    LATENCY   = 2,
  parameter string INIT_FILE = ""
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_readM,
  input  logic                 i_writeM,
  input  logic [WORD_SIZE-1:0] i_address,
  inout  wire  [WORD_SIZE-1:0] i_data,
  output logic                 i_ready,
  input  logic                 d_readM,
  input  logic                 d_writeM,
  input  logic [WORD_SIZE-1:0] d_address,
  inout  wire  [WORD_SIZE-1:0] d_data,
  output logic                 d_ready,
  output logic                 err
`ifdef MEM_RESP_STATS_EN
  ,
  output logic [15:0]          rd_count,
  output logic [15:0]          wr_count
`endif
);
  localparam int DEPTH = 1 << ADDR_BITS;

  logic [WORD_SIZE-1:0] mem_array [0:DEPTH-1];
  logic [WORD_SIZE-1:0] i_rdata_reg, d_rdata_reg;
  logic [ADDR_BITS-1:0] i_mem_addr, d_mem_addr;
  logic i_sample, i_enter_done, i_write_op;
  logic d_sample, d_enter_done, d_write_op;
  logic d_commit;
  logic unused_bits;

  mem_port_fsm #(.ADDR_BITS(ADDR_BITS), .LATENCY(LATENCY)) u_i_fsm (
    .clk        (clk),
    .reset      (reset),
    .rd_req     (i_readM),
    .wr_req     (1'b0),
    .address    (i_address[ADDR_BITS-1:0]),
    .ready      (i_ready),
    .sample     (i_sample),
    .enter_done (i_enter_done),
    .mem_addr   (i_mem_addr),
    .write_op   (i_write_op)
  );

  mem_port_fsm #(.ADDR_BITS(ADDR_BITS), .LATENCY(LATENCY)) u_d_fsm (
    .clk        (clk),
    .reset      (reset),
    .rd_req     (d_readM),
    .wr_req     (d_writeM),
    .address    (d_address[ADDR_BITS-1:0]),
    .ready      (d_ready),
    .sample     (d_sample),
    .enter_done (d_enter_done),
    .mem_addr   (d_mem_addr),
    .write_op   (d_write_op)
  );

  // Write lands on the edge leaving DONE; reset forces the FSM out of
  // DONE asynchronously, so an interrupted write never commits.
  assign d_commit = d_ready && d_write_op;

  // Registered reads and the write share one edge-triggered block, so a
  // read captured on the commit edge sees the old word.
  always_ff @(posedge clk) begin
    if (i_enter_done) i_rdata_reg <= mem_array[i_mem_addr];
    if (d_enter_done) d_rdata_reg <= mem_array[d_mem_addr];
    if (d_commit)     mem_array[d_mem_addr] <= d_data;
  end

  assign i_data = i_ready ? i_rdata_reg : {WORD_SIZE{1'bz}};
  assign d_data = (d_ready && !d_write_op) ? d_rdata_reg : {WORD_SIZE{1'bz}};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err <= 1'b0;
    end else if (d_sample && d_readM && d_writeM) begin
      err <= 1'b1;
    end
  end

`ifdef MEM_RESP_STATS_EN
  logic [15:0] rd_inc;
  assign rd_inc = {15'd0, i_ready} + {15'd0, d_ready && !d_write_op};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_count <= '0;
      wr_count <= '0;
    end else begin
      if (rd_count > (16'hFFFF - rd_inc)) rd_count <= 16'hFFFF;
      else                                rd_count <= rd_count + rd_inc;
      if (d_commit && wr_count != 16'hFFFF) wr_count <= wr_count + 16'd1;
    end
  end
`endif

  // Upper address bits alias by design; the instruction port never writes.
  assign unused_bits = ^{i_writeM, i_address[WORD_SIZE-1:ADDR_BITS],
                         d_address[WORD_SIZE-1:ADDR_BITS], i_sample, i_write_op};
endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;
  localparam int LATENCY = 2;

  typedef struct packed {
    logic        wr;
    logic [15:0] data;
  } d_exp_t;

  logic        clk, reset;
  logic        i_readM, i_writeM, d_readM, d_writeM;
  logic [15:0] i_address, d_address;
  wire  [15:0] i_data, d_data;
  logic        i_ready, d_ready, err;
  logic [15:0] d_drv;
  logic        d_drv_en;
`ifdef MEM_RESP_STATS_EN
  logic [15:0] rd_count, wr_count;
`endif

  int errors = 0;
  int checks = 0;
  int exp_rd = 0;
  int exp_wr = 0;

  logic [15:0] model [0:255];
  logic [15:0] i_q [$];
  d_exp_t      d_q [$];

  assign d_data = d_drv_en ? d_drv : 16'hzzzz;

  mem_responder #(.LATENCY(LATENCY)) dut (
    .clk       (clk),
    .reset     (reset),
    .i_readM   (i_readM),
    .i_writeM  (i_writeM),
    .i_address (i_address),
    .i_data    (i_data),
    .i_ready   (i_ready),
    .d_readM   (d_readM),
    .d_writeM  (d_writeM),
    .d_address (d_address),
    .d_data    (d_data),
    .d_ready   (d_ready),
    .err       (err)
`ifdef MEM_RESP_STATS_EN
    ,
    .rd_count  (rd_count),
    .wr_count  (wr_count)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  // Scoreboard: every ready pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!reset) begin
      if (i_ready) begin
        if (i_q.size() == 0) check_eq("i_unexpected_ready", {31'd0, i_ready}, 32'd0);
        else check_eq("i_data", {16'd0, i_data}, {16'd0, i_q.pop_front()});
      end
      if (d_ready) begin
        if (d_q.size() == 0) begin
          check_eq("d_unexpected_ready", {31'd0, d_ready}, 32'd0);
        end else begin
          d_exp_t e;
          e = d_q.pop_front();
          if (!e.wr) check_eq("d_data", {16'd0, d_data}, {16'd0, e.data});
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic d_access(input logic wr, input logic rd, input logic [15:0] addr,
                          input logic [15:0] data);
    int n;
    logic [7:0] idx;
    idx = addr[7:0];
    d_address = addr;
    d_writeM  = wr;
    d_readM   = rd;
    if (wr) begin
      d_drv    = data;
      d_drv_en = 1'b1;
      model[idx] = data;
      d_q.push_back('{wr: 1'b1, data: data});
      exp_wr++;
    end else begin
      d_q.push_back('{wr: 1'b0, data: model[idx]});
      exp_rd++;
    end
    n = 0;
    do begin
      tick();
      n++;
    end while (!d_ready && n < 20);
    check_eq("d_latency", n, LATENCY);
    d_readM  = 1'b0;
    d_writeM = 1'b0;
    tick();
    d_drv_en = 1'b0;
    check_eq("d_pulse_end", {31'd0, d_ready}, 32'd0);
  endtask

  task automatic i_access(input logic [15:0] addr);
    int n;
    logic [7:0] idx;
    idx = addr[7:0];
    i_address = addr;
    i_readM   = 1'b1;
    i_q.push_back(model[idx]);
    exp_rd++;
    n = 0;
    do begin
      tick();
      n++;
    end while (!i_ready && n < 20);
    check_eq("i_latency", n, LATENCY);
    i_readM  = 1'b0;
    i_writeM = 1'b0;
    tick();
    check_eq("i_pulse_end", {31'd0, i_ready}, 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    i_readM = 0; i_writeM = 0; d_readM = 0; d_writeM = 0;
    i_address = 0; d_address = 0; d_drv = 0; d_drv_en = 0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_i_ready", {31'd0, i_ready}, 32'd0);
    check_eq("rst_d_ready", {31'd0, d_ready}, 32'd0);
    check_eq("rst_err", {31'd0, err}, 32'd0);
`ifdef MEM_RESP_STATS_EN
    check_eq("rst_rd_count", {16'd0, rd_count}, 32'd0);
    check_eq("rst_wr_count", {16'd0, wr_count}, 32'd0);
`endif
    reset = 1'b0;
    tick();

    // Known prior contents for the addresses used below.
    d_access(1'b1, 1'b0, 16'h0010, 16'h1111);
    d_access(1'b1, 1'b0, 16'h0020, 16'h2222);
    d_access(1'b1, 1'b0, 16'h0030, 16'h3333);
    d_access(1'b1, 1'b0, 16'h0031, 16'h3131);

    // 1: write then instruction read
    d_access(1'b1, 1'b0, 16'h0005, 16'h1234);
    i_access(16'h0005);

    // 2: d commit edge coincides with i enter-DONE edge
    d_address = 16'h0010; d_writeM = 1'b1; d_drv = 16'hBEEF; d_drv_en = 1'b1;
    d_q.push_back('{wr: 1'b1, data: 16'hBEEF});
    exp_wr++;
    tick();                       // d sampled
    i_address = 16'h0010; i_readM = 1'b1;
    i_q.push_back(model[8'h10]);  // old word expected
    exp_rd++;
    tick();                       // d in DONE, i sampled
    check_eq("coll_d_ready", {31'd0, d_ready}, 32'd1);
    d_writeM = 1'b0;
    tick();                       // d commits, i enters DONE
    check_eq("coll_i_ready", {31'd0, i_ready}, 32'd1);
    d_drv_en = 1'b0; i_readM = 1'b0;
    model[8'h10] = 16'hBEEF;
    tick();
    i_access(16'h0010);

    // 3: write aborted during WAIT
    d_address = 16'h0020; d_writeM = 1'b1; d_drv = 16'hAAAA; d_drv_en = 1'b1;
    tick();
    d_writeM = 1'b0;
    tick();
    check_eq("abort_no_ready", {31'd0, d_ready}, 32'd0);
    tick();
    check_eq("abort_no_ready2", {31'd0, d_ready}, 32'd0);
    d_drv_en = 1'b0;
    d_access(1'b0, 1'b1, 16'h0020, 16'h0000);

    // 4: address aliasing; i_writeM must be ignored
    d_access(1'b1, 1'b0, 16'h0105, 16'h5555);
    i_writeM = 1'b1;
    i_access(16'h0005);

    // 5: reset in WAIT of a write
    d_address = 16'h0030; d_writeM = 1'b1; d_drv = 16'h7777; d_drv_en = 1'b1;
    tick();
    check_eq("rstwait_in_wait", {31'd0, d_ready}, 32'd0);
    reset = 1'b1;
    #1;
    check_eq("rstwait_d_ready", {31'd0, d_ready}, 32'd0);
    check_eq("rstwait_err", {31'd0, err}, 32'd0);
    tick();
    reset = 1'b0; d_writeM = 1'b0; d_drv_en = 1'b0;
    tick();
    check_eq("rstwait_err_after", {31'd0, err}, 32'd0);
    check_eq("rstwait_i_ready", {31'd0, i_ready}, 32'd0);
    d_access(1'b0, 1'b1, 16'h0030, 16'h0000);

    // 5b: reset during DONE drops ready at once and blocks the commit
    d_address = 16'h0031; d_writeM = 1'b1; d_drv = 16'h9999; d_drv_en = 1'b1;
    tick();
    tick();
    check_eq("rstdone_ready_before", {31'd0, d_ready}, 32'd1);
    reset = 1'b1;
    #1;
    check_eq("rstdone_ready_drop", {31'd0, d_ready}, 32'd0);
    tick();
    reset = 1'b0; d_writeM = 1'b0; d_drv_en = 1'b0;
    tick();
    d_access(1'b0, 1'b1, 16'h0031, 16'h0000);

    // 6: read+write together is a write and raises sticky err
    check_eq("err_before_both", {31'd0, err}, 32'd0);
    d_access(1'b1, 1'b1, 16'h0040, 16'h0F0F);
    check_eq("err_set", {31'd0, err}, 32'd1);
    i_access(16'h0040);
    check_eq("err_sticky", {31'd0, err}, 32'd1);

    repeat (3) tick();
    check_eq("i_q_empty", i_q.size(), 32'd0);
    check_eq("d_q_empty", d_q.size(), 32'd0);
`ifdef MEM_RESP_STATS_EN
    check_eq("stats_rd_count", {16'd0, rd_count}, exp_rd);
    check_eq("stats_wr_count", {16'd0, wr_count}, exp_wr);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
